fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word fetches and keeps an in-order {instruction, pc} buffer; data acked in cycle N is visible in N+1.
// Fetch stalls when the buffer is full; redirects flush it. FETCH_PREFETCH_EN selects a 2-deep buffer (default 1-deep).
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN     = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o
);

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int              CW         = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   FULL       = CW'(DEPTH);
  localparam logic [31:0]     RV_ALIGNED = {RESET_VECTOR[31:2], 2'b00};

  logic          r_run;
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_count;
  logic [31:0]   r_insn [DEPTH];
  logic [31:0]   r_pc   [DEPTH];

  logic [31:0]   w_insn_ext [DEPTH+1];
  logic [31:0]   w_pc_ext   [DEPTH+1];
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_wr_idx;
  logic          w_unused_lsb;

  assign imem_req_o    = r_run & (r_count != FULL);
  assign imem_addr_o   = r_fetch_pc;
  assign instr_valid_o = (r_count != '0);
  assign instruction_o = instr_valid_o ? r_insn[0] : NOP_INSN;
  assign pc_o          = instr_valid_o ? r_pc[0]   : r_fetch_pc;

  assign w_push       = imem_req_o & imem_ack_i & ~redirect_i;
  assign w_pop        = instr_valid_o & instr_ready_i;
  // A simultaneous pop shifts the buffer down, so the new entry lands one slot lower.
  assign w_wr_idx     = r_count - CW'(w_pop);
  assign w_unused_lsb = ^redirect_pc_i[1:0];

  // One spare slot above the top entry keeps the shift index in range for every depth.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_insn_ext[i] = r_insn[i];
      w_pc_ext[i]   = r_pc[i];
    end
    w_insn_ext[DEPTH] = NOP_INSN;
    w_pc_ext[DEPTH]   = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_fetch_pc <= RV_ALIGNED;
      r_count    <= '0;
    end else begin
      r_run <= 1'b1;
      if (redirect_i) begin
        r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
        r_count    <= '0;
      end else begin
        if (w_push) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Payload storage carries no reset; r_count alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_push && (w_wr_idx == CW'(i))) begin
        r_insn[i] <= imem_rdata_i;
        r_pc[i]   <= r_fetch_pc;
      end else if (w_pop) begin
        r_insn[i] <= w_insn_ext[i+1];
        r_pc[i]   <= w_pc_ext[i+1];
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a queue model of the buffer predicts request, address and head contents every cycle.
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [31:0] RV  = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'hE1A0_0000;

  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;

  int          n_checks = 0;
  int          n_fail   = 0;
  ent_t        q[$];
  logic [31:0] exp_pc;
  logic        exp_run;

  fetch_unit #(.RESET_VECTOR(RV), .NOP_INSN(NOP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instruction_o (instruction_o),
    .pc_o          (pc_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req_o},    32'd0);
    chk({tag, "_valid"}, {31'd0, instr_valid_o}, 32'd0);
    chk({tag, "_insn"},  instruction_o,          NOP);
    chk({tag, "_pc"},    pc_o,                   RV);
    chk({tag, "_addr"},  imem_addr_o,            RV);
  endtask

  // Compare current outputs against the model, drive this cycle's inputs, advance the model, clock.
  task automatic step(input logic ack, input logic rdy, input logic redir, input logic [31:0] rpc);
    logic ereq;
    logic pop;
    logic push;
    ent_t e;
    ereq = exp_run && (q.size() < DEPTH);
    chk("req",   {31'd0, imem_req_o},    {31'd0, ereq});
    chk("addr",  imem_addr_o,            exp_pc);
    chk("valid", {31'd0, instr_valid_o}, {31'd0, (q.size() != 0)});
    if (q.size() != 0) begin
      chk("head_insn", instruction_o, q[0].insn);
      chk("head_pc",   pc_o,          q[0].pc);
    end else begin
      chk("idle_insn", instruction_o, NOP);
      chk("idle_pc",   pc_o,          exp_pc);
    end
    imem_ack_i    = ack;
    instr_ready_i = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    imem_rdata_i  = mem_word(imem_addr_o);
    pop  = (q.size() != 0) && rdy;
    push = ereq && ack && !redir;
    if (pop) void'(q.pop_front());
    if (redir) begin
      q.delete();
      exp_pc = {rpc[31:2], 2'b00};
    end else if (push) begin
      e.insn = mem_word(exp_pc);
      e.pc   = exp_pc;
      q.push_back(e);
      exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    exp_run = 1'b1;
  endtask

  initial begin
    rst_n         = 1'b0;
    imem_ack_i    = 1'b1;
    instr_ready_i = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_rdata_i  = '0;
    exp_pc        = RV;
    exp_run       = 1'b0;

    // Held in reset across clock edges.
    #3;
    chk_reset_outputs("rst0");
    @(posedge clk); @(posedge clk); #1;
    chk_reset_outputs("rst1");

    // Release and stream with ack/ready high.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Consumer stalls: buffer fills, request drops, then drains in order.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Redirect while full; low address bits are ignored.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, 32'h0000_1007);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Back-to-back redirects: the last one wins.
    step(1'b1, 1'b1, 1'b1, 32'h0000_2000);
    step(1'b1, 1'b1, 1'b1, 32'h0000_3002);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Address wrap at the top of the address space.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Memory withholds ack: request and address hold, buffer drains to NOP.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0);

    // Mixed random traffic.
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), $urandom);
    end

    // Asynchronous reset with a full buffer: outputs clear without a clock edge.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0);
    chk("full_before_reset", {31'd0, instr_valid_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    @(posedge clk); #1;
    chk_reset_outputs("arst_hold");
    q.delete();
    exp_pc  = RV;
    exp_run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
